// File: rtl/hc595_pkg.sv
// Shared types and sizing helpers for the 74HC595 chain driver.
// Widths depend on instance parameters, so they are derived through these functions.
package hc595_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SH_LO = 2'd1,
    S_SH_HI = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam int BITS_PER_DEV = 8;
  localparam int W_DEFAULT    = BITS_PER_DEV;

  function automatic int word_w(input int n_dev);
    return BITS_PER_DEV * n_dev;
  endfunction

  // max(1, $clog2(div)) so that DIV=1 still gets a 1-bit counter
  function automatic int phase_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  function automatic int bitcnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int PW_DEFAULT = phase_w(1);
  localparam int CW_DEFAULT = bitcnt_w(W_DEFAULT);

endpackage

// File: rtl/hc595_tick.sv
// Phase counter: o_tick marks the last of every DIV clk cycles.
// i_restart holds the count at zero so a new phase starts cleanly.
module hc595_tick
  import hc595_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int PW = phase_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/hc595_chain.sv
// Serialises a W-bit word into a chain of 74HC595 shift registers,
// then pulses the storage clock once to present the word on the outputs.
module hc595_chain
  import hc595_pkg::*;
#(
  parameter  int N_DEV     = 1,
  parameter  int DIV       = 1,
  parameter  int LSB_FIRST = 0,
  localparam int W         = word_w(N_DEV)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_done,
  output logic         o_SHCP,
  output logic         o_STCP,
  output logic         o_DS,
  output logic         o_OE_n
);

  localparam int CW = bitcnt_w(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_t         r_state, w_state_next;
  logic [W-1:0]   r_buf, w_buf_next, w_buf_shift;
  logic [CW-1:0]  r_bitcnt, w_bitcnt_next;
  logic           r_ds, w_ds_next;
  logic           r_done, w_done_next;
  logic           r_oe_n, w_oe_n_next;
  logic           w_tick, w_restart;
  logic           w_first_bit, w_shift_bit;

  // Buffer shifts toward the outgoing end so the next bit is always at a fixed index
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_first_bit = i_data[0];
      assign w_buf_shift = {1'b0, r_buf[W-1:1]};
      assign w_shift_bit = r_buf[1];
    end else begin : g_msb
      assign w_first_bit = i_data[W-1];
      assign w_buf_shift = {r_buf[W-2:0], 1'b0};
      assign w_shift_bit = r_buf[W-2];
    end
  endgenerate

  assign w_restart = (r_state == S_IDLE);

  hc595_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_buf    <= '0;
      r_bitcnt <= '0;
      r_ds     <= 1'b0;
      r_done   <= 1'b0;
      r_oe_n   <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_buf    <= w_buf_next;
      r_bitcnt <= w_bitcnt_next;
      r_ds     <= w_ds_next;
      r_done   <= w_done_next;
      r_oe_n   <= w_oe_n_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_buf_next    = r_buf;
    w_bitcnt_next = r_bitcnt;
    w_ds_next     = r_ds;
    w_done_next   = 1'b0;
    w_oe_n_next   = r_oe_n;
    case (r_state)
      S_IDLE: begin
        w_ds_next = 1'b0;
        if (i_valid) begin
          w_state_next  = S_SH_LO;
          w_buf_next    = i_data;
          w_bitcnt_next = '0;
          w_ds_next     = w_first_bit;
        end
      end
      S_SH_LO: begin
        if (w_tick) begin
          w_state_next = S_SH_HI;
        end
      end
      S_SH_HI: begin
        if (w_tick) begin
          w_bitcnt_next = r_bitcnt + 1'b1;
          if (r_bitcnt == LAST_BIT) begin
            w_state_next = S_LATCH;
            w_ds_next    = 1'b0;
          end else begin
            w_state_next = S_SH_LO;
            w_buf_next   = w_buf_shift;
            w_ds_next    = w_shift_bit;
          end
        end
      end
      S_LATCH: begin
        if (w_tick) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
          w_oe_n_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_SHCP  = (r_state == S_SH_HI);
  assign o_STCP  = (r_state == S_LATCH);
  assign o_DS    = r_ds;
  assign o_done  = r_done;
  assign o_OE_n  = r_oe_n;

endmodule

// File: tb/tb_hc595_chain.sv
// Directed bench for hc595_chain: three instances (MSB-first, LSB-first, 2-device DIV=3)
// share clk/rst; a negedge monitor records the serial stream and pulse counts.
module tb_hc595_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = 3'b000;
  logic [15:0] din [3] = '{default: 16'h0};
  logic        rdy [3];
  logic        done[3];
  logic        shcp[3];
  logic        stcp[3];
  logic        ds  [3];
  logic        oe_n[3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // monitor state, written only by the monitor process
  int          rises [3] = '{default: 0};
  int          stcps [3] = '{default: 0};
  int          dones [3] = '{default: 0};
  int          hi_len[3] = '{default: 0};
  int          hi_bad[3] = '{default: 0};
  logic [15:0] seq   [3] = '{default: 16'h0};
  logic        p_shcp[3] = '{default: 1'b0};
  logic        p_stcp[3] = '{default: 1'b0};
  int          div_of[3] = '{1, 1, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hc595_chain #(.N_DEV(1), .DIV(1), .LSB_FIRST(0)) dut_a (
    .clk(clk), .rst(rst), .i_valid(vld[0]), .i_data(din[0][7:0]),
    .o_ready(rdy[0]), .o_done(done[0]), .o_SHCP(shcp[0]), .o_STCP(stcp[0]),
    .o_DS(ds[0]), .o_OE_n(oe_n[0]));

  hc595_chain #(.N_DEV(1), .DIV(1), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .i_valid(vld[1]), .i_data(din[1][7:0]),
    .o_ready(rdy[1]), .o_done(done[1]), .o_SHCP(shcp[1]), .o_STCP(stcp[1]),
    .o_DS(ds[1]), .o_OE_n(oe_n[1]));

  hc595_chain #(.N_DEV(2), .DIV(3), .LSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .i_valid(vld[2]), .i_data(din[2]),
    .o_ready(rdy[2]), .o_done(done[2]), .o_SHCP(shcp[2]), .o_STCP(stcp[2]),
    .o_DS(ds[2]), .o_OE_n(oe_n[2]));

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (shcp[d] && !p_shcp[d]) begin
        rises[d]  = rises[d] + 1;
        seq[d]    = {seq[d][14:0], ds[d]};
        hi_len[d] = 1;
      end else if (shcp[d]) begin
        hi_len[d] = hi_len[d] + 1;
      end else if (p_shcp[d] && hi_len[d] != div_of[d]) begin
        hi_bad[d] = hi_bad[d] + 1;
      end
      if (stcp[d] && !p_stcp[d]) stcps[d] = stcps[d] + 1;
      if (done[d]) dones[d] = dones[d] + 1;
      p_shcp[d] = shcp[d];
      p_stcp[d] = stcp[d];
    end
  end

  task automatic send(input int d, input logic [15:0] v, output int t_acc);
    @(negedge clk);
    vld[d] = 1'b1;
    din[d] = v;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    t_acc  = cyc;
  endtask

  task automatic wait_done(input int d, input int limit, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (done[d]) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({rdy[d], done[d], shcp[d], stcp[d], ds[d], oe_n[d]} !== 6'b100001) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got rdy/done/shcp/stcp/ds/oe_n=%b, want 100001",
                 d, {rdy[d], done[d], shcp[d], stcp[d], ds[d], oe_n[d]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int t0, t1, r0, s0, h0;
    r0 = rises[0]; s0 = stcps[0]; h0 = hi_bad[0];
    send(0, 16'h00A5, t0);
    n_checks++;
    if (rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: o_ready=%b, want 0", rdy[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    vld[0] = 1'b1; din[0] = 16'h003C;
    repeat (4) @(posedge clk);
    #1;
    vld[0] = 1'b0;
    n_checks++;
    if (oe_n[0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_oe_before_latch: o_OE_n=%b, want 1", oe_n[0]);
    end
    wait_done(0, 100, t1);
    $display("txn dut0 data=a5 latency=%0d", (t1 < 0) ? -1 : t1 - t0);
    n_checks++;
    if (t1 < 0 || t1 - t0 != 17) begin
      n_fail++; $display("FAIL basic_latency: got %0d, want 17", (t1 < 0) ? -1 : t1 - t0);
    end
    n_checks++;
    if (seq[0][7:0] !== 8'hA5) begin
      n_fail++; $display("FAIL basic_bits: sampled %h, want a5", seq[0][7:0]);
    end
    n_checks++;
    if (rises[0] - r0 != 8 || stcps[0] - s0 != 1) begin
      n_fail++; $display("FAIL basic_pulses: shcp=%0d stcp=%0d, want 8 and 1",
                         rises[0] - r0, stcps[0] - s0);
    end
    n_checks++;
    if (rdy[0] !== 1'b1 || oe_n[0] !== 1'b0 || hi_bad[0] != h0) begin
      n_fail++; $display("FAIL basic_after: rdy=%b oe_n=%b hi_bad=%0d, want 1 0 0",
                         rdy[0], oe_n[0], hi_bad[0] - h0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_width: o_done=%b one cycle later, want 0", done[0]);
    end
  endtask

  task automatic test_lsb;
    logic [7:0] vec [2];
    logic [7:0] exp [2];
    int t0, t1;
    vec = '{8'h01, 8'hA0};
    exp = '{8'h80, 8'h05};
    for (int i = 0; i < 2; i++) begin
      send(1, {8'h00, vec[i]}, t0);
      wait_done(1, 100, t1);
      $display("txn dut1 data=%h latency=%0d", vec[i], (t1 < 0) ? -1 : t1 - t0);
      n_checks++;
      if (t1 < 0 || seq[1][7:0] !== exp[i]) begin
        n_fail++; $display("FAIL lsb_order data=%h: sampled %h, want %h", vec[i], seq[1][7:0], exp[i]);
      end
    end
  endtask

  task automatic test_wide;
    int t0, t1, r0, s0, h0;
    r0 = rises[2]; s0 = stcps[2]; h0 = hi_bad[2];
    n_checks++;
    if (oe_n[2] !== 1'b1) begin
      n_fail++; $display("FAIL wide_oe_initial: o_OE_n=%b, want 1", oe_n[2]);
    end
    send(2, 16'hBEEF, t0);
    wait_done(2, 300, t1);
    $display("txn dut2 data=beef latency=%0d", (t1 < 0) ? -1 : t1 - t0);
    n_checks++;
    if (t1 < 0 || t1 - t0 != 99) begin
      n_fail++; $display("FAIL wide_latency: got %0d, want 99", (t1 < 0) ? -1 : t1 - t0);
    end
    n_checks++;
    if (seq[2] !== 16'hBEEF) begin
      n_fail++; $display("FAIL wide_bits: sampled %h, want beef", seq[2]);
    end
    n_checks++;
    if (rises[2] - r0 != 16 || stcps[2] - s0 != 1 || hi_bad[2] != h0) begin
      n_fail++; $display("FAIL wide_pulses: shcp=%0d stcp=%0d bad_high=%0d, want 16 1 0",
                         rises[2] - r0, stcps[2] - s0, hi_bad[2] - h0);
    end
  endtask

  task automatic test_back_to_back;
    int t0, t1, t2, t3, r0, s0;
    r0 = rises[0]; s0 = stcps[0];
    @(negedge clk);
    vld[0] = 1'b1; din[0] = 16'h00FF;
    @(posedge clk);
    #1;
    t0 = cyc;
    repeat (2) @(posedge clk);
    #1;
    din[0] = 16'h0000;
    wait_done(0, 100, t1);
    $display("txn dut0 data=ff latency=%0d", (t1 < 0) ? -1 : t1 - t0);
    n_checks++;
    if (t1 < 0 || t1 - t0 != 17 || rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: latency=%0d rdy=%b, want 17 1",
                         (t1 < 0) ? -1 : t1 - t0, rdy[0]);
    end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    t2 = cyc;
    n_checks++;
    if (rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept_in_done_cycle: o_ready=%b, want 0", rdy[0]);
    end
    wait_done(0, 100, t3);
    $display("txn dut0 data=00 latency=%0d", (t3 < 0) ? -1 : t3 - t2);
    n_checks++;
    if (t3 < 0 || t3 - t0 != 35) begin
      n_fail++; $display("FAIL b2b_total: got %0d, want 35", (t3 < 0) ? -1 : t3 - t0);
    end
    n_checks++;
    if (seq[0] !== 16'hFF00 || rises[0] - r0 != 16 || stcps[0] - s0 != 2) begin
      n_fail++; $display("FAIL b2b_stream: bits=%h shcp=%0d stcp=%0d, want ff00 16 2",
                         seq[0], rises[0] - r0, stcps[0] - s0);
    end
  endtask

  task automatic test_reset_abort;
    int t0, t1, r0, s0, d0;
    r0 = rises[0];
    send(0, 16'h00A5, t0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (rises[0] - r0 >= 4) break;
    end
    rst = 1'b1;
    s0 = stcps[0]; d0 = dones[0];
    #1;
    n_checks++;
    if (rises[0] - r0 != 4 ||
        {rdy[0], done[0], shcp[0], stcp[0], ds[0], oe_n[0]} !== 6'b100001) begin
      n_fail++; $display("FAIL abort_outputs: edges=%0d rdy/done/shcp/stcp/ds/oe_n=%b, want 4 100001",
                         rises[0] - r0, {rdy[0], done[0], shcp[0], stcp[0], ds[0], oe_n[0]});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vld[0] = 1'b1; din[0] = 16'h005A;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    t0 = cyc;
    n_checks++;
    if (rdy[0] !== 1'b0 || oe_n[0] !== 1'b1 || dones[0] != d0 || stcps[0] != s0) begin
      n_fail++; $display("FAIL abort_recover: rdy=%b oe_n=%b done_pulses=%0d stcp=%0d, want 0 1 0 0",
                         rdy[0], oe_n[0], dones[0] - d0, stcps[0] - s0);
    end
    wait_done(0, 100, t1);
    $display("txn dut0 data=5a latency=%0d", (t1 < 0) ? -1 : t1 - t0);
    n_checks++;
    if (t1 < 0 || t1 - t0 != 17 || seq[0][7:0] !== 8'h5A || oe_n[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_next_txn: latency=%0d bits=%h oe_n=%b, want 17 5a 0",
                         (t1 < 0) ? -1 : t1 - t0, seq[0][7:0], oe_n[0]);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset;
    test_basic;
    test_lsb;
    test_wide;
    test_back_to_back;
    test_reset_abort;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hc595_chain.md
HC595_CHAIN -- requirements
Module: hc595_chain

Interface
REQ-001 Parameter N_DEV, default 1: number of cascaded 74HC595 devices; shift word width W = 8*N_DEV.
REQ-002 Parameter DIV, default 1: clk cycles per serial half-period; legal range 1..255.
REQ-003 Parameter LSB_FIRST, default 0: 0 shifts bit W-1 first, 1 shifts bit 0 first.
REQ-004 clk  input  1  single system clock (27 MHz board clock); all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 i_valid  input  1  request to send i_data.
REQ-007 i_data  input  W  word to shift into the chain.
REQ-008 o_ready  output  1  block idle and able to accept a word.
REQ-009 o_done  output  1  one-cycle pulse when the latch phase completes.
REQ-010 o_SHCP  output  1  shift-register clock to the chain (data sampled on its rising edge).
REQ-011 o_STCP  output  1  storage-register (latch) clock to the chain.
REQ-012 o_DS  output  1  serial data to the first device.
REQ-013 o_OE_n  output  1  active-low output enable to the chain.

Function
REQ-014 FSM states: IDLE, SH_LO, SH_HI, LATCH; each non-IDLE state lasts exactly DIV clk cycles, timed by a phase counter of width max(1,$clog2(DIV)).
REQ-015 Accept occurs on an edge where i_valid && o_ready; i_data is copied into an internal W-bit buffer, bit counter cleared, state goes to SH_LO.
REQ-016 o_ready is 1 only in IDLE; i_valid in any other state is ignored and i_data changes there have no effect.
REQ-017 o_DS is updated on the edge entering SH_LO with the next bit in the selected order; it is stable throughout SH_LO and SH_HI.
REQ-018 o_SHCP is 0 in SH_LO and 1 in SH_HI; exactly W rising edges of o_SHCP per transaction.
REQ-019 After SH_HI of bit W-1 the state goes to LATCH; o_STCP is 1 in LATCH only, giving one rising edge per transaction; o_SHCP is 0 in LATCH.
REQ-020 On leaving LATCH the state returns to IDLE; o_done is 1 for exactly that first IDLE cycle.
REQ-021 Latency: o_done asserts (2*W+1)*DIV cycles after the accept edge; 17 cycles for N_DEV=1, DIV=1.
REQ-022 o_ready is 1 in the o_done cycle; a word presented then is accepted, so back-to-back transfers have no idle gap.
REQ-023 o_OE_n is 1 from reset until the first LATCH completes, then 0, and stays 0 until the next reset.
REQ-024 Bit counter width is $clog2(W+1); it does not wrap within a transaction.
REQ-025 o_DS is 0 in IDLE.

Reset
REQ-026 While rst is 1: state IDLE, o_SHCP=0, o_STCP=0, o_DS=0, o_done=0, o_ready=1, o_OE_n=1, and all counters and the buffer are 0.
REQ-027 Reset during a transfer aborts it immediately; no o_done pulse occurs and the partial word is never latched.
REQ-028 The first accept is possible on the first posedge after rst deasserts.

Structure
REQ-029 Package hc595_pkg holds the state encoding and the localparams for W and the counter widths.
REQ-030 Sub-module hc595_tick (DIV-cycle phase counter with restart input and tick output) is instantiated once; the FSM advances on its tick.

Verification
REQ-031 N_DEV=1, DIV=1, MSB-first, i_data=8'hA5 -> DS at the 8 SHCP rising edges is 1,0,1,0,0,1,0,1; one STCP pulse; o_done 17 cycles after accept; o_OE_n falls.
REQ-032 LSB_FIRST=1, i_data=8'h01 -> first sampled bit is 1, remaining seven are 0.
REQ-033 N_DEV=2, DIV=3, i_data=16'hBEEF -> 16 SHCP pulses each high 3 cycles; o_done 99 cycles after accept.
REQ-034 i_valid held high with 8'hFF then 8'h00 -> second word accepted in the o_done cycle; SHCP pulse train continuous; two STCP pulses.
REQ-035 rst asserted after the 4th SHCP rising edge -> all outputs at reset values immediately; no o_done; o_OE_n=1; o_ready=1.
REQ-036 During a transfer, i_valid=1 with i_data=8'h3C -> ignored; shifted bits match the originally accepted word.
